// File: rtl/dsp_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dsp_ctrl_pkg
// Shared types and constants for the DSP48A1 multiply-accumulate controller.
//   state_t     : controller FSM states
//   OPMODE_ACC  : OPMODE for P <= P + M (X = M, Z = P, post-adder add)
//   VLD_DEPTH   : number of pipeline stages between the A/B registers and P
// -----------------------------------------------------------------------------
package dsp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] OPMODE_ACC = 8'h09;
    localparam int         VLD_DEPTH  = 2;

endpackage

// File: rtl/dsp_vld_pipe.sv
// -----------------------------------------------------------------------------
// dsp_vld_pipe
// Delayed-valid shift register that tracks an accepted operand pair as it
// travels A/B register -> M register -> P register inside the DSP slice.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset, empties the pipeline
//   in_vld : operand pair accepted this cycle (A/B registers loading)
//   vld    : vld[0] = M register loading, vld[1] = P register loading
// -----------------------------------------------------------------------------
module dsp_vld_pipe
    import dsp_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    output logic [VLD_DEPTH-1:0] vld
);

    logic vld_p1;
    logic vld_p2;

    // Stage 1: product being registered in M
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_vld;
        end
    end

    // Stage 2: product being accumulated into P
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
        end
    end

    assign vld = {vld_p2, vld_p1};

endmodule

// File: rtl/dsp_mac_ctrl.sv
// -----------------------------------------------------------------------------
// dsp_mac_ctrl
// Sequencer for a DSP48A1 slice computing one dot product per job:
// clears P, accepts len operand pairs with a valid/ready handshake, steers
// the A/B, M and P clock enables so each pair is accumulated exactly once,
// waits for the pipeline to drain and pulses done while P holds the sum.
//
// Optional feature (macro DSP_MAC_TIMEOUT_EN): adds output err and a
// starvation timer; TO_CYC consecutive FEED cycles without op_valid abort
// the job through DRAIN/DONE with err set.
//
// Parameters:
//   LEN_W  : width of len
//   TO_CYC : starvation limit in cycles (timeout build only)
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : begin a job (ignored while busy)
//   len       : operand pairs in the job, captured with start
//   op_valid  : operand pair present at the slice inputs
//   op_ready  : pair accepted this cycle when op_valid is also high
//   opmode    : DSP48A1 OPMODE, fixed accumulate setting
//   ce_ab     : A/B input register enable
//   ce_m      : M register enable
//   ce_p      : P register enable
//   rst_p     : synchronous clear for P
//   busy      : job in progress
//   done      : one-cycle completion pulse
//   err       : starvation timeout occurred (timeout build only)
// -----------------------------------------------------------------------------
module dsp_mac_ctrl
    import dsp_ctrl_pkg::*;
#(
    parameter int LEN_W  = 8,
    parameter int TO_CYC = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             op_valid,
    output logic             op_ready,
    output logic [7:0]       opmode,
    output logic             ce_ab,
    output logic             ce_m,
    output logic             ce_p,
    output logic             rst_p,
    output logic             busy,
`ifdef DSP_MAC_TIMEOUT_EN
    output logic             done,
    output logic             err
`else
    output logic             done
`endif
);

    state_t                 state;
    state_t                 state_nxt;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       remaining;
    logic                   hs;
    logic                   clear_p;
    logic                   timeout_hit;
    logic [VLD_DEPTH-1:0]   vld_pipe;

    assign opmode = OPMODE_ACC;
    assign hs     = op_valid & op_ready;
    assign ce_ab  = hs;
    assign ce_m   = vld_pipe[0];
    assign ce_p   = vld_pipe[1];

    // P is held in clear for as long as reset is asserted, not only after it
    assign rst_p  = rst | clear_p;

    dsp_vld_pipe u_vld_pipe (
        .clk    (clk),
        .rst    (rst),
        .in_vld (hs),
        .vld    (vld_pipe)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        op_ready  = 1'b0;
        clear_p   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (len != '0) ? ST_CLEAR : ST_DONE;
                end
            end
            ST_CLEAR: begin
                clear_p   = 1'b1;
                state_nxt = ST_FEED;
            end
            ST_FEED: begin
                op_ready = 1'b1;
                if ((hs && remaining == LEN_W'(1)) || timeout_hit) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Once stage 1 is empty, the only product left (if any) is
                // entering P on this edge, so P is final in the next cycle.
                if (!vld_pipe[0]) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q <= '0;
        end else if (state == ST_IDLE && start) begin
            len_q <= len;
        end
    end

    // Decrement is guarded so the count can never wrap below zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
        end else if (state == ST_CLEAR) begin
            remaining <= len_q;
        end else if (hs && remaining != '0) begin
            remaining <= remaining - LEN_W'(1);
        end
    end

`ifdef DSP_MAC_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYC + 1);

    logic [TO_W-1:0] idle_cnt;
    logic            err_q;

    // Fires on the TO_CYC-th consecutive starved FEED cycle
    assign timeout_hit = (state == ST_FEED) && !op_valid &&
                         (idle_cnt == TO_W'(TO_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (state != ST_FEED || op_valid) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: doc/dsp_mac_ctrl.md
DSP_MAC_CTRL -- requirements
Module: dsp_mac_ctrl

Interface
REQ-001 Parameter LEN_W, default 8, SHALL set the width of the product-count input.
REQ-002 Parameter TO_CYC, default 256, SHALL set the starvation-timeout limit in cycles (used only under REQ-031).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 start  input  1  request to begin one dot-product job.
REQ-006 len  input  LEN_W  number of operand pairs in the job, sampled when start is accepted.
REQ-007 op_valid  input  1  upstream has an A/B operand pair on the slice inputs.
REQ-008 op_ready  output  1  controller accepts the operand pair this cycle.
REQ-009 opmode  output  8  DSP48A1 OPMODE bus.
REQ-010 ce_ab  output  1  clock enable for the A/B input registers.
REQ-011 ce_m  output  1  clock enable for the M register.
REQ-012 ce_p  output  1  clock enable for the P register.
REQ-013 rst_p  output  1  synchronous clear for the P register.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse; P holds the final sum during this cycle.

Function
REQ-016 States SHALL be IDLE, CLEAR, FEED, DRAIN, DONE.
REQ-017 IDLE: start=1 with len!=0 -> CLEAR; start=1 with len=0 -> DONE; otherwise stay in IDLE.
REQ-018 CLEAR: exactly one cycle, rst_p=1, remaining <= len, -> FEED.
REQ-019 FEED: op_ready=1; a handshake (op_valid & op_ready) SHALL assert ce_ab in the same cycle and decrement remaining.
REQ-020 FEED: a handshake while remaining=1 SHALL move to DRAIN; op_ready SHALL be 0 from the next cycle.
REQ-021 ce_m SHALL equal the handshake delayed 1 cycle; ce_p SHALL equal the handshake delayed 2 cycles (3-stage A/B->M->P latency).
REQ-022 DRAIN SHALL last until the delayed-valid pipeline is empty, i.e. 2 cycles after the last handshake, then -> DONE.
REQ-023 DONE: done=1 for exactly one cycle, -> IDLE.
REQ-024 opmode SHALL be constant 8'h09 (X=M, Z=P, add) in every state.
REQ-025 Gaps in op_valid during FEED SHALL deassert ce_ab, ce_m and ce_p in the matching cycles, so P is never double-accumulated.
REQ-026 start SHALL be ignored whenever busy=1.
REQ-027 remaining SHALL never wrap below 0; len=2^LEN_W-1 SHALL be supported.

Reset
REQ-028 rst=1 SHALL immediately force IDLE and clear remaining and the valid pipeline, irrespective of clk.
REQ-029 During and after reset, op_ready, ce_ab, ce_m, ce_p, busy and done SHALL be 0, rst_p SHALL be 1, and opmode SHALL be 8'h09.
REQ-030 Reset asserted mid-job SHALL abandon the job without producing a done pulse.

Configuration
REQ-031 With macro DSP_MAC_TIMEOUT_EN defined: an extra output err (1 bit) SHALL be added. TO_CYC consecutive FEED cycles with op_valid=0 SHALL set err=1 and go to DRAIN then DONE; err SHALL clear on the next accepted start or on reset.
REQ-032 Without DSP_MAC_TIMEOUT_EN, the err port and its counter SHALL be absent, and FEED SHALL wait indefinitely.

Structure
REQ-033 Package dsp_ctrl_pkg SHALL hold the state enum, OPMODE_ACC=8'h09 and the pipeline depth constant (2).
REQ-034 The 2-stage delayed-valid shift register SHALL be a sub-module dsp_vld_pipe (async reset, output per stage); the FSM and counter stay in dsp_mac_ctrl.

Verification
REQ-035 Reset with start=1 and op_valid=1 -> all CEs 0, rst_p=1, busy=0; after release, IDLE is held until start.
REQ-036 start with len=4 and op_valid held high -> rst_p for 1 cycle, 4 ce_ab cycles, ce_p pulses 2 cycles after each ce_ab, done 3 cycles after the last handshake; sum of A*B pairs (3*5, 2*7, 1*1, 4*4) -> P=46.
REQ-037 len=3 with op_valid toggled 1,0,0,1,0,1 -> exactly 3 ce_ab, ce_m and ce_p pulses at the delayed positions; P equals the exact sum.
REQ-038 len=0 -> done 1 cycle after start, with no CE or rst_p activity.
REQ-039 Reset asserted 2 cycles into FEED of a len=8 job -> IDLE immediately, no done; a new start with len=1 then completes correctly.
REQ-040 With DSP_MAC_TIMEOUT_EN and TO_CYC=16, op_valid low for 16 cycles in FEED -> err=1, followed by DRAIN, then done.
